id_ex_pipe_reg: RTL and testbench
=================================

// Module: id_ex_pipe_reg
// PURPOSE
//   ID/EX pipeline register: latches decoded control, operands and the rs/rt/rd fields.
//   Its ex_rt/ex_rd outputs drive the 5-bit RegDst destination mux in EX.
//   Contains load-use hazard detection that stalls PC and IF/ID and injects a bubble into EX.
//   Also supports an external stall (hold) and a branch flush.
// PARAMETERS
//   DATA_W   32  width of PC+4, operands and sign-extended immediate
//   REG_W    5   register specifier width
//   ALUOP_W  2   ALU operation code width
// PORTS
//   clk            in   1        rising-edge clock
//   reset_n        in   1        synchronous reset, active low
//   stall          in   1        external stall: hold every EX output
//   flush          in   1        branch taken: next EX contents are a bubble
//   id_valid       in   1        ID holds a real instruction
//   id_ctrl        in   7        {reg_dst,alu_src,mem_to_reg,reg_write,mem_read,mem_write,branch}
//   id_alu_op      in   ALUOP_W  ALU operation code
//   id_pc_plus4    in   DATA_W   PC+4 of the ID instruction
//   id_rd1/id_rd2  in   DATA_W   register file read data
//   id_imm         in   DATA_W   sign-extended immediate
//   id_rs/rt/rd    in   REG_W    instruction register fields
//   ex_valid       out  1        EX holds a real instruction
//   ex_ctrl        out  7        latched control bits, same order as id_ctrl
//   ex_alu_op      out  ALUOP_W  latched ALU operation code
//   ex_pc_plus4    out  DATA_W   latched PC+4
//   ex_rd1/ex_rd2  out  DATA_W   latched operands
//   ex_imm         out  DATA_W   latched immediate
//   ex_rs/rt/rd    out  REG_W    latched register fields; rt/rd feed the RegDst mux
//   hazard_stall   out  1        combinational: hold PC and IF/ID this cycle
// BEHAVIOUR
//   - Reset: when reset_n=0 at a clk edge, every ex_* output goes to 0 (valid, ctrl,
//     alu_op, data, rs/rt/rd). Reset takes priority over all other inputs.
//   - Load-use detection (combinational):
//       hazard_stall = id_valid & ex_valid & ex_ctrl.mem_read & (ex_rt!=0)
//                      & (ex_rt==id_rs | ex_rt==id_rt)
//     The stall/flush inputs do not gate hazard_stall. The consumer combines them.
//   - Per-edge priority (reset_n=1 case), highest first:
//       1. flush=1        -> bubble: ex_valid=0, ex_ctrl=0, ex_alu_op=0; other fields are don't-care
//       2. stall=1        -> hold all ex_* outputs unchanged
//       3. hazard_stall=1 -> bubble (as in 1). The ID instruction is re-presented next cycle
//       4. otherwise      -> load: every ex_* output takes its id_* input; ex_valid=id_valid
//   - id_valid=0 on a load -> the ex_ctrl bits are forced to 0. Writes never occur from invalid slots.
//   - Latency: 1 cycle from ID inputs to EX outputs. No combinational path id_* -> ex_*.
//   - A bubble clears reg_write and mem_write. This makes it architecturally a NOP.
//   - The hazard lasts exactly 1 cycle per load-use pair. After the bubble, ex_valid=0,
//     so hazard_stall deasserts.
//   - rt=0 never raises a hazard (register $zero).
//   - Reset deasserted mid-stall: the first edge with reset_n=1 follows the normal priority.
// TESTING
//   - Reset: drive all id_* to nonzero, reset_n=0 for 2 edges -> all ex_* = 0, hazard_stall=0
//   - Pass-through: id_rs=3, rt=4, rd=5, rd1=0x11, ctrl=7'b1001000 -> next cycle ex_* equal,
//     ex_valid=1
//   - Load-use: EX lw rt=8 (mem_read=1); ID add rs=8 -> hazard_stall=1; next cycle ex_valid=0,
//     ex_ctrl=0; ID re-presented -> loads, and hazard_stall=0
//   - No false hazard: EX lw rt=0, ID rs=0 -> hazard_stall=0. EX sw (mem_read=0) rt=8,
//     ID rs=8 -> 0
//   - Stall vs flush: stall=1 for 3 cycles -> ex_* frozen. flush=1 together with stall=1 ->
//     bubble wins
//   - Mid-hazard reset: hazard_stall=1 and reset_n=0 -> all ex_* = 0. Next edge loads
//     normally

Source files
------------

// File: rtl/id_ex_pipe_reg_if.sv
// ID/EX boundary bundle: ID-side instruction fields, EX-side latched copies,
// the external stall/flush controls and the load-use hazard indication.
interface id_ex_pipe_reg_if #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int ALUOP_W = 2
);
  logic               stall;
  logic               flush;
  logic               id_valid;
  logic [6:0]         id_ctrl;
  logic [ALUOP_W-1:0] id_alu_op;
  logic [DATA_W-1:0]  id_pc_plus4;
  logic [DATA_W-1:0]  id_rd1;
  logic [DATA_W-1:0]  id_rd2;
  logic [DATA_W-1:0]  id_imm;
  logic [REG_W-1:0]   id_rs;
  logic [REG_W-1:0]   id_rt;
  logic [REG_W-1:0]   id_rd;
  logic               ex_valid;
  logic [6:0]         ex_ctrl;
  logic [ALUOP_W-1:0] ex_alu_op;
  logic [DATA_W-1:0]  ex_pc_plus4;
  logic [DATA_W-1:0]  ex_rd1;
  logic [DATA_W-1:0]  ex_rd2;
  logic [DATA_W-1:0]  ex_imm;
  logic [REG_W-1:0]   ex_rs;
  logic [REG_W-1:0]   ex_rt;
  logic [REG_W-1:0]   ex_rd;
  logic               hazard_stall;

  // Pipeline front end: drives ID fields and controls, observes EX side.
  modport master (
    output stall, flush, id_valid, id_ctrl, id_alu_op, id_pc_plus4,
           id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd,
    input  ex_valid, ex_ctrl, ex_alu_op, ex_pc_plus4, ex_rd1, ex_rd2,
           ex_imm, ex_rs, ex_rt, ex_rd, hazard_stall
  );

  // The pipeline register itself.
  modport slave (
    input  stall, flush, id_valid, id_ctrl, id_alu_op, id_pc_plus4,
           id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd,
    output ex_valid, ex_ctrl, ex_alu_op, ex_pc_plus4, ex_rd1, ex_rd2,
           ex_imm, ex_rs, ex_rt, ex_rd, hazard_stall
  );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use hazard detection.
// A load in EX whose (nonzero) rt is read by the ID instruction raises
// hazard_stall for one cycle; the register then takes a bubble while PC and
// IF/ID hold, so the ID instruction is re-presented on the following cycle.
module id_ex_pipe_reg #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int ALUOP_W = 2
) (
  input logic              clk,
  input logic              reset_n,
  id_ex_pipe_reg_if.slave  bus
);
  // Bit position of mem_read inside {reg_dst,alu_src,mem_to_reg,reg_write,mem_read,mem_write,branch}
  localparam int MEM_READ_BIT = 2;

  logic               ex_valid_reg,    ex_valid_next;
  logic [6:0]         ex_ctrl_reg,     ex_ctrl_next;
  logic [ALUOP_W-1:0] ex_alu_op_reg,   ex_alu_op_next;
  logic [DATA_W-1:0]  ex_pc_plus4_reg, ex_pc_plus4_next;
  logic [DATA_W-1:0]  ex_rd1_reg,      ex_rd1_next;
  logic [DATA_W-1:0]  ex_rd2_reg,      ex_rd2_next;
  logic [DATA_W-1:0]  ex_imm_reg,      ex_imm_next;
  logic [REG_W-1:0]   ex_rs_reg,       ex_rs_next;
  logic [REG_W-1:0]   ex_rt_reg,       ex_rt_next;
  logic [REG_W-1:0]   ex_rd_reg,       ex_rd_next;

  // Source register fields of the ID instruction that may consume the load result.
  logic [REG_W-1:0] src_field [2];
  logic [1:0]       src_match;
  logic             hazard;
  logic             take_bubble;
  logic             take_load;

  assign src_field[0] = bus.id_rs;
  assign src_field[1] = bus.id_rt;

  for (genvar gi = 0; gi < 2; gi++) begin : g_src_match
    assign src_match[gi] = (ex_rt_reg == src_field[gi]);
  end

  // Load-use: EX holds a valid load writing a real register that ID reads.
  // Deliberately not gated by stall/flush; the consumer combines them.
  assign hazard = bus.id_valid & ex_valid_reg & ex_ctrl_reg[MEM_READ_BIT]
                & (ex_rt_reg != '0) & (|src_match);

  // Flush beats stall; stall beats the hazard bubble; otherwise load.
  assign take_bubble = bus.flush | (~bus.stall & hazard);
  assign take_load   = ~bus.flush & ~bus.stall & ~hazard;

  // Next-state selection: hold by default, bubble clears the control path,
  // load copies ID fields with control forced off for invalid slots.
  always_comb begin
    ex_valid_next    = ex_valid_reg;
    ex_ctrl_next     = ex_ctrl_reg;
    ex_alu_op_next   = ex_alu_op_reg;
    ex_pc_plus4_next = ex_pc_plus4_reg;
    ex_rd1_next      = ex_rd1_reg;
    ex_rd2_next      = ex_rd2_reg;
    ex_imm_next      = ex_imm_reg;
    ex_rs_next       = ex_rs_reg;
    ex_rt_next       = ex_rt_reg;
    ex_rd_next       = ex_rd_reg;
    if (take_bubble) begin
      ex_valid_next  = 1'b0;
      ex_ctrl_next   = '0;
      ex_alu_op_next = '0;
    end else if (take_load) begin
      ex_valid_next    = bus.id_valid;
      ex_ctrl_next     = bus.id_valid ? bus.id_ctrl : 7'd0;
      ex_alu_op_next   = bus.id_alu_op;
      ex_pc_plus4_next = bus.id_pc_plus4;
      ex_rd1_next      = bus.id_rd1;
      ex_rd2_next      = bus.id_rd2;
      ex_imm_next      = bus.id_imm;
      ex_rs_next       = bus.id_rs;
      ex_rt_next       = bus.id_rt;
      ex_rd_next       = bus.id_rd;
    end
  end

  // State update; synchronous active-low reset clears every EX field.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ex_valid_reg    <= 1'b0;
      ex_ctrl_reg     <= '0;
      ex_alu_op_reg   <= '0;
      ex_pc_plus4_reg <= '0;
      ex_rd1_reg      <= '0;
      ex_rd2_reg      <= '0;
      ex_imm_reg      <= '0;
      ex_rs_reg       <= '0;
      ex_rt_reg       <= '0;
      ex_rd_reg       <= '0;
    end else begin
      ex_valid_reg    <= ex_valid_next;
      ex_ctrl_reg     <= ex_ctrl_next;
      ex_alu_op_reg   <= ex_alu_op_next;
      ex_pc_plus4_reg <= ex_pc_plus4_next;
      ex_rd1_reg      <= ex_rd1_next;
      ex_rd2_reg      <= ex_rd2_next;
      ex_imm_reg      <= ex_imm_next;
      ex_rs_reg       <= ex_rs_next;
      ex_rt_reg       <= ex_rt_next;
      ex_rd_reg       <= ex_rd_next;
    end
  end

  assign bus.ex_valid     = ex_valid_reg;
  assign bus.ex_ctrl      = ex_ctrl_reg;
  assign bus.ex_alu_op    = ex_alu_op_reg;
  assign bus.ex_pc_plus4  = ex_pc_plus4_reg;
  assign bus.ex_rd1       = ex_rd1_reg;
  assign bus.ex_rd2       = ex_rd2_reg;
  assign bus.ex_imm       = ex_imm_reg;
  assign bus.ex_rs        = ex_rs_reg;
  assign bus.ex_rt        = ex_rt_reg;
  assign bus.ex_rd        = ex_rd_reg;
  assign bus.hazard_stall = hazard;
endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Bench for id_ex_pipe_reg: reset sequence, directed vector table, then
// randomized traffic checked against a behavioural model of the EX stage.
module tb_id_ex_pipe_reg;
  localparam logic [6:0] C_ADD = 7'b1001000;
  localparam logic [6:0] C_LW  = 7'b0111100;
  localparam logic [6:0] C_SW  = 7'b0100010;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  id_ex_pipe_reg_if bus ();

  id_ex_pipe_reg dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        rn, st, fl, v;
    logic [6:0]  ctrl;
    logic [4:0]  rs, rt, rd;
    logic [31:0] rd1;
    logic        haz;
    logic        ev;
    logic [6:0]  ectrl;
    logic        chk;
    logic [4:0]  ers, ert, erd;
    logic [31:0] erd1;
  } vec_t;

  // Architectural view of what the EX stage should contain.
  typedef struct {
    logic        valid;
    logic [6:0]  ctrl;
    logic [1:0]  alu;
    logic [31:0] pc, rd1, rd2, imm;
    logic [4:0]  rs, rt, rd;
    logic        known;   // data fields are meaningful (not left over from a bubble)
  } ex_t;

  vec_t vecs [23];
  ex_t  m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rn, input logic st, input logic fl, input logic v,
                       input logic [6:0] ctrl, input logic [1:0] alu, input logic [31:0] pc,
                       input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    reset_n         = rn;
    bus.stall       = st;
    bus.flush       = fl;
    bus.id_valid    = v;
    bus.id_ctrl     = ctrl;
    bus.id_alu_op   = alu;
    bus.id_pc_plus4 = pc;
    bus.id_rd1      = rd1;
    bus.id_rd2      = rd2;
    bus.id_imm      = imm;
    bus.id_rs       = rs;
    bus.id_rt       = rt;
    bus.id_rd       = rd;
  endtask

  function automatic vec_t mk(input logic rn, input logic st, input logic fl, input logic v,
                              input logic [6:0] ctrl, input logic [4:0] rs, input logic [4:0] rt,
                              input logic [4:0] rd, input logic [31:0] rd1, input logic haz,
                              input logic ev, input logic [6:0] ectrl, input logic chkd,
                              input logic [4:0] ers, input logic [4:0] ert, input logic [4:0] erd,
                              input logic [31:0] erd1);
    vec_t r;
    r.rn = rn; r.st = st; r.fl = fl; r.v = v; r.ctrl = ctrl;
    r.rs = rs; r.rt = rt; r.rd = rd; r.rd1 = rd1; r.haz = haz;
    r.ev = ev; r.ectrl = ectrl; r.chk = chkd;
    r.ers = ers; r.ert = ert; r.erd = erd; r.erd1 = erd1;
    return r;
  endfunction

  // A valid load in EX whose nonzero destination rt is read by a valid ID instruction.
  function automatic logic model_hazard(input ex_t e, input logic v, input logic [4:0] rs,
                                        input logic [4:0] rt);
    logic ex_is_load;
    ex_is_load = e.valid && e.ctrl[2];
    return v && ex_is_load && (e.rt != 5'd0) && (e.rt == rs || e.rt == rt);
  endfunction

  initial begin
    total = 0;
    bad   = 0;

    // ---- Reset: nonzero ID inputs held through two reset edges ----
    drive(1'b0, 1'b0, 1'b0, 1'b1, C_LW, 2'b11, 32'hAAAA_0004, 32'h1111_1111,
          32'h2222_2222, 32'h3333_3333, 5'd7, 5'd8, 5'd9);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("rst_ctrl",  {25'd0, bus.ex_ctrl}, 32'd0);
    chk("rst_alu",   {30'd0, bus.ex_alu_op}, 32'd0);
    chk("rst_pc",    bus.ex_pc_plus4, 32'd0);
    chk("rst_rd1",   bus.ex_rd1, 32'd0);
    chk("rst_rd2",   bus.ex_rd2, 32'd0);
    chk("rst_imm",   bus.ex_imm, 32'd0);
    chk("rst_regs",  {17'd0, bus.ex_rs, bus.ex_rt, bus.ex_rd}, 32'd0);
    chk("rst_haz",   {31'd0, bus.hazard_stall}, 32'd0);

    // ---- Directed vectors: hazard expected before the edge, EX after it ----
    vecs[0]  = mk(1,0,0,1,C_ADD, 3, 4, 5,32'h11, 0, 1,C_ADD,1, 3, 4, 5,32'h11);
    vecs[1]  = mk(1,0,0,1,C_LW,  2, 8, 0,32'h22, 0, 1,C_LW, 1, 2, 8, 0,32'h22);
    vecs[2]  = mk(1,0,0,1,C_ADD, 8, 9,10,32'h33, 1, 0,7'd0, 0, 0, 0, 0,32'h0);
    vecs[3]  = mk(1,0,0,1,C_ADD, 8, 9,10,32'h33, 0, 1,C_ADD,1, 8, 9,10,32'h33);
    vecs[4]  = mk(1,0,0,1,C_LW,  1, 0, 0,32'h44, 0, 1,C_LW, 1, 1, 0, 0,32'h44);
    vecs[5]  = mk(1,0,0,1,C_ADD, 0, 7, 6,32'h55, 0, 1,C_ADD,1, 0, 7, 6,32'h55);
    vecs[6]  = mk(1,0,0,1,C_SW,  2, 8, 0,32'h66, 0, 1,C_SW, 1, 2, 8, 0,32'h66);
    vecs[7]  = mk(1,0,0,1,C_ADD, 8, 3, 4,32'h77, 0, 1,C_ADD,1, 8, 3, 4,32'h77);
    vecs[8]  = mk(1,1,0,1,C_LW,  9, 9, 9,32'h88, 0, 1,C_ADD,1, 8, 3, 4,32'h77);
    vecs[9]  = mk(1,1,0,1,C_LW,  9, 9, 9,32'h88, 0, 1,C_ADD,1, 8, 3, 4,32'h77);
    vecs[10] = mk(1,1,0,1,C_LW,  9, 9, 9,32'h88, 0, 1,C_ADD,1, 8, 3, 4,32'h77);
    vecs[11] = mk(1,1,1,1,C_LW,  9, 9, 9,32'h88, 0, 0,7'd0, 0, 0, 0, 0,32'h0);
    vecs[12] = mk(1,0,0,1,C_LW,  1, 8, 0,32'h99, 0, 1,C_LW, 1, 1, 8, 0,32'h99);
    vecs[13] = mk(1,0,0,0,C_ADD, 8, 8, 2,32'hAA, 0, 0,7'd0, 1, 8, 8, 2,32'hAA);
    vecs[14] = mk(1,0,0,1,C_LW,  3,12, 0,32'hBB, 0, 1,C_LW, 1, 3,12, 0,32'hBB);
    vecs[15] = mk(1,1,0,1,C_ADD, 5,12, 1,32'hCC, 1, 1,C_LW, 1, 3,12, 0,32'hBB);
    vecs[16] = mk(1,0,0,1,C_ADD, 5,12, 1,32'hCC, 1, 0,7'd0, 0, 0, 0, 0,32'h0);
    vecs[17] = mk(1,0,0,1,C_ADD, 5,12, 1,32'hCC, 0, 1,C_ADD,1, 5,12, 1,32'hCC);
    vecs[18] = mk(1,0,0,1,C_LW,  1,13, 0,32'hDD, 0, 1,C_LW, 1, 1,13, 0,32'hDD);
    vecs[19] = mk(0,0,0,1,C_ADD,13, 2, 3,32'hEE, 1, 0,7'd0, 1, 0, 0, 0,32'h0);
    vecs[20] = mk(1,0,0,1,C_ADD,13, 2, 3,32'hEE, 0, 1,C_ADD,1,13, 2, 3,32'hEE);
    vecs[21] = mk(1,0,1,1,C_ADD, 1, 2, 3,32'h12, 0, 0,7'd0, 0, 0, 0, 0,32'h0);
    vecs[22] = mk(1,0,0,1,C_ADD, 1, 2, 3,32'h12, 0, 1,C_ADD,1, 1, 2, 3,32'h12);

    for (int i = 0; i < 23; i++) begin
      drive(vecs[i].rn, vecs[i].st, vecs[i].fl, vecs[i].v, vecs[i].ctrl, vecs[i].rd1[1:0],
            32'h100 + vecs[i].rd1, vecs[i].rd1, ~vecs[i].rd1, vecs[i].rd1 ^ 32'hFFFF_0000,
            vecs[i].rs, vecs[i].rt, vecs[i].rd);
      @(negedge clk);
      chk($sformatf("v%0d_haz", i), {31'd0, bus.hazard_stall}, {31'd0, vecs[i].haz});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), {31'd0, bus.ex_valid}, {31'd0, vecs[i].ev});
      chk($sformatf("v%0d_ctrl", i), {25'd0, bus.ex_ctrl}, {25'd0, vecs[i].ectrl});
      if (vecs[i].chk) begin
        chk($sformatf("v%0d_regs", i), {17'd0, bus.ex_rs, bus.ex_rt, bus.ex_rd},
            {17'd0, vecs[i].ers, vecs[i].ert, vecs[i].erd});
        chk($sformatf("v%0d_rd1", i), bus.ex_rd1, vecs[i].erd1);
      end
      $display("vec %0d: haz=%0b valid=%0b ctrl=%b rs=%0d rt=%0d rd=%0d", i,
               bus.hazard_stall, bus.ex_valid, bus.ex_ctrl, bus.ex_rs, bus.ex_rt, bus.ex_rd);
    end

    // ---- Random traffic against the behavioural model ----
    drive(1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 2'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    @(posedge clk);
    #1;
    m = '{valid: 1'b0, ctrl: 7'd0, alu: 2'd0, pc: 32'd0, rd1: 32'd0, rd2: 32'd0,
          imm: 32'd0, rs: 5'd0, rt: 5'd0, rd: 5'd0, known: 1'b1};

    for (int n = 0; n < 400; n++) begin
      logic        rn, st, fl, v, exp_haz;
      logic [6:0]  ctrl;
      logic [1:0]  alu;
      logic [31:0] pc, rd1, rd2, imm;
      logic [4:0]  rs, rt, rd;
      rn   = ($urandom_range(0, 19) != 0);
      st   = ($urandom_range(0, 6) == 0);
      fl   = ($urandom_range(0, 7) == 0);
      v    = ($urandom_range(0, 7) != 0);
      ctrl = 7'($urandom);
      alu  = 2'($urandom);
      pc   = $urandom;
      rd1  = $urandom;
      rd2  = $urandom;
      imm  = $urandom;
      rs   = 5'($urandom_range(0, 3));
      rt   = 5'($urandom_range(0, 3));
      rd   = 5'($urandom);
      drive(rn, st, fl, v, ctrl, alu, pc, rd1, rd2, imm, rs, rt, rd);
      exp_haz = model_hazard(m, v, rs, rt);
      @(negedge clk);
      chk($sformatf("r%0d_haz", n), {31'd0, bus.hazard_stall}, {31'd0, exp_haz});
      @(posedge clk);
      if (!rn) begin
        m = '{valid: 1'b0, ctrl: 7'd0, alu: 2'd0, pc: 32'd0, rd1: 32'd0, rd2: 32'd0,
              imm: 32'd0, rs: 5'd0, rt: 5'd0, rd: 5'd0, known: 1'b1};
      end else if (fl || (!st && exp_haz)) begin
        m.valid = 1'b0;
        m.ctrl  = 7'd0;
        m.alu   = 2'd0;
        m.known = 1'b0;
      end else if (!st) begin
        m = '{valid: v, ctrl: (v ? ctrl : 7'd0), alu: alu, pc: pc, rd1: rd1, rd2: rd2,
              imm: imm, rs: rs, rt: rt, rd: rd, known: 1'b1};
      end
      #1;
      chk($sformatf("r%0d_valid", n), {31'd0, bus.ex_valid}, {31'd0, m.valid});
      chk($sformatf("r%0d_ctrl", n), {25'd0, bus.ex_ctrl}, {25'd0, m.ctrl});
      chk($sformatf("r%0d_alu", n), {30'd0, bus.ex_alu_op}, {30'd0, m.alu});
      if (m.known) begin
        chk($sformatf("r%0d_pc", n), bus.ex_pc_plus4, m.pc);
        chk($sformatf("r%0d_rd1", n), bus.ex_rd1, m.rd1);
        chk($sformatf("r%0d_rd2", n), bus.ex_rd2, m.rd2);
        chk($sformatf("r%0d_imm", n), bus.ex_imm, m.imm);
        chk($sformatf("r%0d_regs", n), {17'd0, bus.ex_rs, bus.ex_rt, bus.ex_rd},
            {17'd0, m.rs, m.rt, m.rd});
      end
      $display("rand %0d: rn=%0b st=%0b fl=%0b haz=%0b valid=%0b ctrl=%b", n, rn, st, fl,
               exp_haz, bus.ex_valid, bus.ex_ctrl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
